// File: rtl/reg_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_alu_seq_pkg
// Shared definitions for the reg_alu command sequencer:
//   - FSM state encodings (kept as plain localparam constants so that existing
//     Verilog-2001 code that compares against the raw codes keeps working)
//   - command kind codes
//   - ALU opcode names for the reg_alu datapath
//   - the packed record of latched command fields
//   - a helper that maps an accepted command kind to its first state
// Optional feature macro used by the top module: REG_ALU_SEQ_PERF_EN.
// -----------------------------------------------------------------------------
package reg_alu_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_LDI  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Command kind codes (2'b11 is reserved and handled like a NOP)
    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_LDI = 2'b01;
    localparam logic [1:0] KIND_NOP = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    // ALU opcodes understood by the reg_alu datapath
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Command fields captured on the accept edge (immediate kept separately
    // because its width follows DATA_W)
    typedef struct packed {
        logic [1:0] op;
        logic [2:0] dst;
        logic [2:0] src_a;
        logic [2:0] src_b;
    } cmd_fields_t;

    // First state entered after a command of the given kind is accepted.
    function automatic logic [2:0] kind_to_state(input logic [1:0] kind);
        case (kind)
            KIND_ALU: return ST_EXEC;
            KIND_LDI: return ST_LDI;
            default:  return ST_DONE;   // NOP and reserved
        endcase
    endfunction

endpackage

// File: rtl/reg_alu_seq_rptcnt.sv
// -----------------------------------------------------------------------------
// reg_alu_seq_rptcnt
// Loadable RPT_W-bit down-counter used as the ALU repeat counter.
// The counter never wraps by decrementing: a decrement request at zero is
// ignored, so the only way to get a new count is a reload.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-low reset (count -> 0)
//   i_load      in   load i_load_val (has priority over i_dec)
//   i_load_val  in   RPT_W value to load
//   i_dec       in   decrement request
//   o_zero      out  count == 0
// -----------------------------------------------------------------------------
module reg_alu_seq_rptcnt #(
    parameter int RPT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [RPT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [RPT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/reg_alu_seq.sv
// -----------------------------------------------------------------------------
// reg_alu_seq
// Command sequencer for the 8x16 register-file/ALU datapath (reg_alu).
// Accepts one command at a time (valid/ready) and drives the datapath control
// and address ports on a fixed schedule:
//   ALU : EXEC, WB repeated cmd_rpt+1 times, then DONE
//   LDI : LDI, DONE
//   NOP : DONE            (reserved kind 2'b11 behaves like NOP)
// Carry-out of the ALU is captured into carry_flag on every WB edge.
//
// Optional feature (macro REG_ALU_SEQ_PERF_EN): adds 16-bit wrapping counters
// retire_cnt (done pulses) and wr_cnt (cycles with alu_wr high).
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_kind/op/dst/src_a/src_b/rpt/imm   command fields
//   alu_sel               write-mux select (1 = ALU result, 0 = d_in)
//   alu_wr                register-file write enable (gated by reset)
//   alu_op                ALU opcode
//   rd_addr_a/rd_addr_b   read addresses
//   wr_addr               write address
//   d_in                  immediate data for LDI
//   alu_cout              ALU carry-out
//   carry_flag            last captured carry
//   busy                  state != IDLE
//   done                  one-cycle completion pulse
//   retire_cnt, wr_cnt    performance counters (REG_ALU_SEQ_PERF_EN only)
// -----------------------------------------------------------------------------
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RPT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_dst,
    input  logic [2:0]        cmd_src_a,
    input  logic [2:0]        cmd_src_b,
    input  logic [RPT_W-1:0]  cmd_rpt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              alu_sel,
    output logic              alu_wr,
    output logic [1:0]        alu_op,
    output logic [2:0]        rd_addr_a,
    output logic [2:0]        rd_addr_b,
    output logic [2:0]        wr_addr,
    output logic [DATA_W-1:0] d_in,
    input  logic              alu_cout,
    output logic              carry_flag,
    output logic              busy,
    output logic              done
`ifdef REG_ALU_SEQ_PERF_EN
    ,
    output logic [15:0]       retire_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    cmd_fields_t       r_cmd;
    logic [DATA_W-1:0] r_imm;
    logic              r_carry;

    logic              w_accept;
    logic              w_rpt_load;
    logic              w_rpt_dec;
    logic              w_rpt_zero;

    // ---------------------------------------------------------------------
    // Handshake: ready depends on state only, never on cmd_valid.
    // ---------------------------------------------------------------------
    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // ---------------------------------------------------------------------
    // Repeat counter
    // ---------------------------------------------------------------------
    assign w_rpt_load = w_accept && (cmd_kind == KIND_ALU);
    assign w_rpt_dec  = (r_state == ST_WB) && !w_rpt_zero;

    reg_alu_seq_rptcnt #(
        .RPT_W (RPT_W)
    ) u_rptcnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_rpt_load),
        .i_load_val (cmd_rpt),
        .i_dec      (w_rpt_dec),
        .o_zero     (w_rpt_zero)
    );

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = kind_to_state(cmd_kind);
                end
            end
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = w_rpt_zero ? ST_DONE : ST_EXEC;
            ST_LDI:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, latched command fields and carry flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_imm   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cmd.op    <= cmd_op;
                r_cmd.dst   <= cmd_dst;
                r_cmd.src_a <= cmd_src_a;
                r_cmd.src_b <= cmd_src_b;
                r_imm       <= cmd_imm;
            end
            if (r_state == ST_WB) begin
                r_carry <= alu_cout;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output decode
    // Addresses, opcode and immediate are driven straight from the latched
    // fields: they only matter in EXEC/WB/LDI and otherwise hold their last
    // latched values, which are all zero after reset.
    // ---------------------------------------------------------------------
    assign rd_addr_a  = r_cmd.src_a;
    assign rd_addr_b  = r_cmd.src_b;
    assign wr_addr    = r_cmd.dst;
    assign alu_op     = r_cmd.op;
    assign d_in       = r_imm;

    assign alu_sel    = (r_state == ST_EXEC) || (r_state == ST_WB);
    // Reset gates the write enable directly so an in-flight WB/LDI cannot
    // write in the cycle where reset is asserted.
    assign alu_wr     = reset && ((r_state == ST_WB) || (r_state == ST_LDI));
    assign done       = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign carry_flag = r_carry;

`ifdef REG_ALU_SEQ_PERF_EN
    // ---------------------------------------------------------------------
    // Performance counters, both wrap naturally at 16 bits.
    // ---------------------------------------------------------------------
    logic [15:0] r_retire_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retire_cnt <= '0;
            r_wr_cnt     <= '0;
        end else begin
            if (done) begin
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (alu_wr) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign wr_cnt     = r_wr_cnt;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_alu_seq
// Directed bench for reg_alu_seq. A small behavioural model of the reg_alu
// datapath (8x16 register file + ALU) is attached so that register results
// and carry can be checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_reg_alu_seq;

    localparam int DATA_W = 16;
    localparam int RPT_W  = 4;

    localparam logic [1:0] K_ALU = 2'b00;
    localparam logic [1:0] K_LDI = 2'b01;
    localparam logic [1:0] K_NOP = 2'b10;
    localparam logic [1:0] K_RSV = 2'b11;
    localparam logic [1:0] OP_ADD = 2'b00;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [1:0]        cmd_op;
    logic [2:0]        cmd_dst;
    logic [2:0]        cmd_src_a;
    logic [2:0]        cmd_src_b;
    logic [RPT_W-1:0]  cmd_rpt;
    logic [DATA_W-1:0] cmd_imm;
    logic              alu_sel;
    logic              alu_wr;
    logic [1:0]        alu_op;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] d_in;
    logic              alu_cout;
    logic              carry_flag;
    logic              busy;
    logic              done;
`ifdef REG_ALU_SEQ_PERF_EN
    logic [15:0]       retire_cnt;
    logic [15:0]       wr_cnt;
`endif

    always #5 clk = ~clk;

    reg_alu_seq #(
        .DATA_W (DATA_W),
        .RPT_W  (RPT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_rpt    (cmd_rpt),
        .cmd_imm    (cmd_imm),
        .alu_sel    (alu_sel),
        .alu_wr     (alu_wr),
        .alu_op     (alu_op),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .wr_addr    (wr_addr),
        .d_in       (d_in),
        .alu_cout   (alu_cout),
        .carry_flag (carry_flag),
        .busy       (busy),
        .done       (done)
`ifdef REG_ALU_SEQ_PERF_EN
        ,
        .retire_cnt (retire_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    // ---------------------------------------------------------------------
    // Behavioural datapath: register file plus ALU
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;

    assign sum = {1'b0, rf[rd_addr_a]} + {1'b0, rf[rd_addr_b]};

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: begin alu_res = sum[DATA_W-1:0]; alu_cout = sum[DATA_W]; end
            2'b01: alu_res = rf[rd_addr_a] - rf[rd_addr_b];
            2'b10: alu_res = rf[rd_addr_a] & rf[rd_addr_b];
            default: alu_res = rf[rd_addr_a] | rf[rd_addr_b];
        endcase
    end

    always @(posedge clk) begin
        if (alu_wr) rf[wr_addr] <= alu_sel ? alu_res : d_in;
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Snapshot of the outputs in the first cycle after the accept edge
    logic              f_wr, f_sel;
    logic [2:0]        f_waddr;
    logic [DATA_W-1:0] f_din;

    // Issue one command from IDLE (caller sits #1 after an edge), then count
    // cycles to done and write pulses seen. Returns one cycle after DONE (IDLE).
    task automatic run_cmd(input logic [1:0] kind, input logic [1:0] op,
                           input logic [2:0] dst, input logic [2:0] a,
                           input logic [2:0] b, input logic [RPT_W-1:0] rpt,
                           input logic [DATA_W-1:0] imm,
                           output int lat, output int wrs);
        cmd_valid = 1'b1;
        cmd_kind  = kind;  cmd_op = op;  cmd_dst = dst;
        cmd_src_a = a;     cmd_src_b = b; cmd_rpt = rpt; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        f_wr = alu_wr; f_sel = alu_sel; f_waddr = wr_addr; f_din = d_in;
        lat = 0;
        wrs = 0;
        for (int n = 1; n <= 64; n++) begin
            if (alu_wr) wrs++;
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    int lat, wrs;
    logic saw;

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_kind  = K_LDI; cmd_op = '0; cmd_dst = 3'd7;
        cmd_src_a = 3'd7;  cmd_src_b = 3'd7; cmd_rpt = '0; cmd_imm = 16'hFFFF;

        // Reset held for two edges with a command offered
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("rst_ready", cmd_ready, 1);
            check_eq("rst_busy",  busy, 0);
            check_eq("rst_wr",    alu_wr, 0);
            check_eq("rst_carry", carry_flag, 0);
        end
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", {rd_addr_a, rd_addr_b, wr_addr}, 0);
        check_eq("rst_din",  d_in, 0);
        check_eq("rst_sel",  alu_sel, 0);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;

        // LDI r3 <- 0x1234
        run_cmd(K_LDI, 2'b00, 3'd3, 3'd0, 3'd0, 4'd0, 16'h1234, lat, wrs);
        check_eq("ldi_wr",    f_wr, 1);
        check_eq("ldi_sel",   f_sel, 0);
        check_eq("ldi_waddr", f_waddr, 3);
        check_eq("ldi_din",   f_din, 16'h1234);
        check_eq("ldi_lat",   lat, 2);
        check_eq("ldi_wrs",   wrs, 1);
        check_eq("ldi_carry", carry_flag, 0);
        check_eq("ldi_r3",    rf[3], 16'h1234);

        // r1 = r2 = 0x8000, then r4 = r1 + r2 (carry out)
        run_cmd(K_LDI, 2'b00, 3'd1, 3'd0, 3'd0, 4'd0, 16'h8000, lat, wrs);
        run_cmd(K_LDI, 2'b00, 3'd2, 3'd0, 3'd0, 4'd0, 16'h8000, lat, wrs);
        check_eq("ldi2_lat", lat, 2);
        run_cmd(K_ALU, OP_ADD, 3'd4, 3'd1, 3'd2, 4'd0, 16'h0000, lat, wrs);
        check_eq("add_exec_wr",  f_wr, 0);
        check_eq("add_exec_sel", f_sel, 1);
        check_eq("add_lat",   lat, 3);
        check_eq("add_wrs",   wrs, 1);
        check_eq("add_r4",    rf[4], 16'h0000);
        check_eq("add_carry", carry_flag, 1);

        // LDI leaves carry untouched
        run_cmd(K_LDI, 2'b00, 3'd6, 3'd0, 3'd0, 4'd0, 16'h0001, lat, wrs);
        check_eq("ldi_keep_carry", carry_flag, 1);

        // Accumulate r5 = 1 doubled four times
        run_cmd(K_LDI, 2'b00, 3'd5, 3'd0, 3'd0, 4'd0, 16'h0001, lat, wrs);
        run_cmd(K_ALU, OP_ADD, 3'd5, 3'd5, 3'd5, 4'd3, 16'h0000, lat, wrs);
        check_eq("acc_lat",   lat, 9);
        check_eq("acc_wrs",   wrs, 4);
        check_eq("acc_r5",    rf[5], 16'h0010);
        check_eq("acc_carry", carry_flag, 0);

        // NOP and reserved kind
        run_cmd(K_NOP, 2'b00, 3'd0, 3'd0, 3'd0, 4'd5, 16'h0000, lat, wrs);
        check_eq("nop_lat", lat, 1);
        check_eq("nop_wrs", wrs, 0);
        run_cmd(K_RSV, 2'b00, 3'd0, 3'd0, 3'd0, 4'd5, 16'h0000, lat, wrs);
        check_eq("rsv_lat", lat, 1);
        check_eq("rsv_wrs", wrs, 0);

        // rpt all-ones: r6 = 1 doubled 16 times -> 0 with final carry
        run_cmd(K_ALU, OP_ADD, 3'd6, 3'd6, 3'd6, 4'hF, 16'h0000, lat, wrs);
        check_eq("max_lat",   lat, 33);
        check_eq("max_wrs",   wrs, 16);
        check_eq("max_r6",    rf[6], 16'h0000);
        check_eq("max_carry", carry_flag, 1);

        // Reset during the second WB of an rpt=2 command
        run_cmd(K_LDI, 2'b00, 3'd6, 3'd0, 3'd0, 4'd0, 16'h0000, lat, wrs);
        cmd_valid = 1'b1;
        cmd_kind  = K_ALU; cmd_op = OP_ADD; cmd_dst = 3'd0;
        cmd_src_a = 3'd1;  cmd_src_b = 3'd2; cmd_rpt = 4'd2;
        @(posedge clk); #1;                           // EXEC 1
        cmd_valid = 1'b0;
        check_eq("mid_busy", busy, 1);
        @(posedge clk); #1;                           // WB 1
        check_eq("mid_wb1_wr", alu_wr, 1);
        @(posedge clk); #1;                           // EXEC 2
        check_eq("mid_carry1", carry_flag, 1);
        @(posedge clk); #1;                           // WB 2
        check_eq("mid_wb2_wr", alu_wr, 1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_wr", alu_wr, 0);
        @(posedge clk); #1;
        check_eq("mid_idle_busy",  busy, 0);
        check_eq("mid_idle_ready", cmd_ready, 1);
        check_eq("mid_carry_clr",  carry_flag, 0);
        reset = 1'b1;
        saw = done;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            saw = saw | done;
        end
        check_eq("mid_no_done", saw, 0);

        // Back-to-back with cmd_valid held: NOP then LDI
        cmd_valid = 1'b1;
        cmd_kind  = K_NOP;
        @(posedge clk); #1;                           // DONE of NOP
        cmd_kind = K_LDI; cmd_dst = 3'd7; cmd_imm = 16'hBEEF;
        check_eq("b2b_done",  done, 1);
        check_eq("b2b_ready", cmd_ready, 0);
        check_eq("b2b_busy",  busy, 1);
        @(posedge clk); #1;                           // IDLE, LDI offered
        check_eq("b2b_idle_ready", cmd_ready, 1);
        check_eq("b2b_idle_wr",    alu_wr, 0);
        @(posedge clk); #1;                           // LDI accepted
        cmd_valid = 1'b0;
        check_eq("b2b_ldi_wr",  alu_wr, 1);
        check_eq("b2b_ldi_din", d_in, 16'hBEEF);
        @(posedge clk); #1;
        check_eq("b2b_ldi_done", done, 1);
        @(posedge clk); #1;
        check_eq("b2b_r7", rf[7], 16'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
